mem_arbiter: RTL and testbench

//  Two-port arbiter directly downstream of the caches: merges the icache (port 0) and dcache (port 1)

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arb_tag_fifo.sv | 70 +++++++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the two-port memory arbiter.
//   PORT_I    - icache port index (port 0)
//   PORT_D    - dcache port index (port 1)
//   NUM_PORTS - number of requesting ports
//   port_t    - 1-bit port identifier carried through the tag FIFO
package mem_arbiter_pkg;

  localparam int PORT_I    = 0;
  localparam int PORT_D    = 1;
  localparam int NUM_PORTS = 2;

  typedef logic port_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: 1-bit wide, DEPTH-deep FIFO of port ids for outstanding
// reads. Reads return in issue order, so the head always names the port that
// owns the next memory response.
//   i_clk, i_rst_n  clock / async active-low reset
//   i_push, i_din   enqueue a port id (ignored when full)
//   i_pop           dequeue head (ignored when empty)
//   o_dout          current head
//   o_full/o_empty  derived from the registered occupancy count
module mem_arb_tag_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_push,
  input  port_t i_din,
  input  logic  i_pop,
  output port_t o_dout,
  output logic  o_full,
  output logic  o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_dout  = mem_q[rd_ptr_q];

  // Pointers are power-of-2 wide, so the increment wraps mod DEPTH for free.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges icache (port 0) and dcache (port 1) word interfaces
// onto one backing-memory port. One hold entry per port, one winner per
// cycle, registered ren/wen pulses, read data routed back by an in-order tag
// FIFO.
//   i_clk, i_rst_n                 clock / async active-low reset
//   o_pN_ready                     port N may present a request this cycle
//   i_pN_addr/ren/wen/wdata        port N request
//   o_pN_rdata/valid               port N read response (combinational)
//   i_mem_ready                    memory accepts a command
//   o_mem_addr/ren/wen/wdata       registered memory command
//   i_mem_rdata/valid              in-order memory read response
//   o_err                          sticky: response seen with no read outstanding
// Build option: MEM_ARB_RR_EN selects round-robin on ties; otherwise the
// dcache port always wins ties.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_p0_ready,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic              i_p0_ren,
  input  logic              i_p0_wen,
  input  logic [DATA_W-1:0] i_p0_wdata,
  output logic [DATA_W-1:0] o_p0_rdata,
  output logic              o_p0_valid,
  output logic              o_p1_ready,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic              i_p1_ren,
  input  logic              i_p1_wen,
  input  logic [DATA_W-1:0] i_p1_wdata,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic              o_p1_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_ren,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_valid,
  output logic              o_err
);
  import mem_arbiter_pkg::*;

  logic [NUM_PORTS-1:0]             req_rd, req_wr, rdy, iss;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr, hold_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata, hold_wdata;
  logic [NUM_PORTS-1:0]             hold_v, hold_wr;

  port_t win, head;
  logic  win_wr, issue, push, pop, fifo_full, fifo_empty;

  logic              mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;

  assign req_rd    = {i_p1_ren,   i_p0_ren};
  assign req_wr    = {i_p1_wen,   i_p0_wen};
  assign req_addr  = {i_p1_addr,  i_p0_addr};
  assign req_wdata = {i_p1_wdata, i_p0_wdata};

  // Per-port hold entry. Ready is independent of the request strobes so the
  // cache can drive them from ready without a combinational loop.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic              hold_v_q, hold_v_d, hold_wr_q, hold_wr_d, acc;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;

    assign iss[g] = issue && (win == port_t'(g));
    assign rdy[g] = ~hold_v_q | iss[g];
    assign acc    = rdy[g] & (req_rd[g] | req_wr[g]);

    // A refill on the issuing edge overrides the clear.
    always_comb begin
      hold_v_d     = hold_v_q;
      hold_wr_d    = hold_wr_q;
      hold_addr_d  = hold_addr_q;
      hold_wdata_d = hold_wdata_q;
      if (iss[g]) hold_v_d = 1'b0;
      if (acc) begin
        hold_v_d     = 1'b1;
        hold_wr_d    = req_wr[g];
        hold_addr_d  = req_addr[g];
        hold_wdata_d = req_wdata[g];
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hold_v_q     <= 1'b0;
        hold_wr_q    <= 1'b0;
        hold_addr_q  <= '0;
        hold_wdata_q <= '0;
      end else begin
        hold_v_q     <= hold_v_d;
        hold_wr_q    <= hold_wr_d;
        hold_addr_q  <= hold_addr_d;
        hold_wdata_q <= hold_wdata_d;
      end
    end

    assign hold_v[g]     = hold_v_q;
    assign hold_wr[g]    = hold_wr_q;
    assign hold_addr[g]  = hold_addr_q;
    assign hold_wdata[g] = hold_wdata_q;
  end

`ifdef MEM_ARB_RR_EN
  // rr_q holds the last winner; resets to dcache so icache goes first.
  port_t rr_q, rr_d;
  assign rr_d = issue ? win : rr_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_q <= port_t'(PORT_D);
    else          rr_q <= rr_d;
  end
`endif

  always_comb begin
    win = port_t'(PORT_I);
    if (hold_v[PORT_I] && hold_v[PORT_D]) begin
`ifdef MEM_ARB_RR_EN
      win = ~rr_q;
`else
      win = port_t'(PORT_D);
`endif
    end else if (hold_v[PORT_D]) begin
      win = port_t'(PORT_D);
    end
  end

  // Writes never occupy a tag, so they may issue while the tag FIFO is full.
  assign win_wr = hold_wr[win];
  assign issue  = i_mem_ready & (|hold_v) & (~fifo_full | win_wr);
  assign push   = issue & ~win_wr;
  assign pop    = i_mem_valid & ~fifo_empty;

  mem_arb_tag_fifo #(.DEPTH(RSP_DEPTH)) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_din   (win),
    .i_pop   (pop),
    .o_dout  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (issue) begin
      mem_ren_d   = ~win_wr;
      mem_wen_d   = win_wr;
      mem_addr_d  = hold_addr[win];
      mem_wdata_d = hold_wdata[win];
    end
    err_d = err_q | (i_mem_valid & fifo_empty);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign o_p0_ready  = rdy[PORT_I];
  assign o_p1_ready  = rdy[PORT_D];
  assign o_mem_ren   = mem_ren_q;
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_err       = err_q;

  assign o_p0_valid = pop & (head == port_t'(PORT_I));
  assign o_p1_valid = pop & (head == port_t'(PORT_D));
  assign o_p0_rdata = o_p0_valid ? i_mem_rdata : '0;
  assign o_p1_rdata = o_p1_valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked before the
// next rising edge. Expectations for tie-breaking follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_ready, p0_ren, p0_wen, p0_valid;
  logic          p1_ready, p1_ren, p1_wen, p1_valid;
  logic [AW-1:0] p0_addr, p1_addr, mem_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic          mem_ready, mem_ren, mem_wen, mem_valid, err;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  bit first_p1;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_p0_ready(p0_ready), .i_p0_addr(p0_addr), .i_p0_ren(p0_ren), .i_p0_wen(p0_wen),
    .i_p0_wdata(p0_wdata), .o_p0_rdata(p0_rdata), .o_p0_valid(p0_valid),
    .o_p1_ready(p1_ready), .i_p1_addr(p1_addr), .i_p1_ren(p1_ren), .i_p1_wen(p1_wen),
    .i_p1_wdata(p1_wdata), .o_p1_rdata(p1_rdata), .o_p1_valid(p1_valid),
    .i_mem_ready(mem_ready), .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid), .o_err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_ren = 0; p0_wen = 0; p0_addr = '0; p0_wdata = '0;
    p1_ren = 0; p1_wen = 0; p1_addr = '0; p1_wdata = '0;
    mem_ready = 1; mem_valid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  initial begin
    first_p1 = !RR;
    do_reset();
    chk("rst_ren", mem_ren, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);
    chk("rst_p0_ready", p0_ready, 1);
    chk("rst_p1_ready", p1_ready, 1);

    // 1: single p0 read
    p0_addr = 32'h100; p0_ren = 1;
    cyc(); p0_ren = 0; #1;
    chk("t1_no_cmd_at_accept", mem_ren, 0);
    chk("t1_p0_ready_on_issue", p0_ready, 1);
    cyc();
    chk("t1_ren", mem_ren, 1);
    chk("t1_addr", mem_addr, 32'h100);
    cyc();
    chk("t1_ren_pulse_end", mem_ren, 0);
    cyc(); cyc();
    mem_valid = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("t1_p0_valid", p0_valid, 1);
    chk("t1_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("t1_p1_valid", p1_valid, 0);
    chk("t1_p1_rdata", p1_rdata, 0);
    cyc(); mem_valid = 0; #1;
    chk("t1_p0_valid_end", p0_valid, 0);
    chk("t1_no_err", err, 0);

    // 2: simultaneous requests from both ports
    do_reset();
    p0_addr = 32'h200; p0_ren = 1; p1_addr = 32'h300; p1_ren = 1;
    cyc(); p0_ren = 0; p1_ren = 0; #1;
    chk("t2_p0_ready", p0_ready, first_p1 ? 0 : 1);
    chk("t2_p1_ready", p1_ready, first_p1 ? 1 : 0);
    cyc();
    chk("t2_first_ren", mem_ren, 1);
    chk("t2_first_addr", mem_addr, first_p1 ? 32'h300 : 32'h200);
    cyc();
    chk("t2_second_ren", mem_ren, 1);
    chk("t2_second_addr", mem_addr, first_p1 ? 32'h200 : 32'h300);
    cyc();
    chk("t2_idle", mem_ren, 0);
    mem_valid = 1; mem_rdata = 32'hA; #1;
    chk("t2_rspA_p0_valid", p0_valid, first_p1 ? 0 : 1);
    chk("t2_rspA_p1_valid", p1_valid, first_p1 ? 1 : 0);
    chk("t2_rspA_rdata", first_p1 ? p1_rdata : p0_rdata, 32'hA);
    cyc(); mem_rdata = 32'hB; #1;
    chk("t2_rspB_p0_valid", p0_valid, first_p1 ? 1 : 0);
    chk("t2_rspB_p1_valid", p1_valid, first_p1 ? 0 : 1);
    chk("t2_rspB_rdata", first_p1 ? p0_rdata : p1_rdata, 32'hB);
    cyc(); mem_valid = 0; #1;
    chk("t2_no_err", err, 0);

    // 3: p1 burst with memory stalled two cycles
    do_reset();
    p1_addr = 32'h40; p1_ren = 1;
    cyc(); p1_addr = 32'h44; #1;
    chk("t3_ready_on_issue", p1_ready, 1);
    cyc();
    chk("t3_ren0", mem_ren, 1);
    chk("t3_addr0", mem_addr, 32'h40);
    mem_ready = 0; p1_addr = 32'h48; #1;
    chk("t3_ready_low_a", p1_ready, 0);
    cyc();
    chk("t3_stall_a", mem_ren, 0);
    chk("t3_ready_low_b", p1_ready, 0);
    cyc();
    chk("t3_stall_b", mem_ren, 0);
    mem_ready = 1; #1;
    chk("t3_ready_back", p1_ready, 1);
    cyc();
    chk("t3_addr1", mem_addr, 32'h44);
    chk("t3_ren1", mem_ren, 1);
    p1_addr = 32'h4C;
    cyc();
    chk("t3_addr2", mem_addr, 32'h48);
    p1_ren = 0;
    cyc();
    chk("t3_addr3", mem_addr, 32'h4C);
    chk("t3_ren3", mem_ren, 1);
    cyc();
    chk("t3_done", mem_ren, 0);

    // 4: tag FIFO full blocks reads, not writes
    do_reset();
    p0_ren = 1; p0_addr = 32'h10;
    cyc(); p0_addr = 32'h14;
    cyc(); p0_addr = 32'h18;
    cyc(); p0_addr = 32'h1C;
    cyc(); p0_addr = 32'h20;
    cyc();
    chk("t4_fourth_ren", mem_ren, 1);
    chk("t4_fourth_addr", mem_addr, 32'h1C);
    p0_ren = 0; p1_addr = 32'h90; p1_wdata = 32'h55; p1_wen = 1; #1;
    chk("t4_p0_ready_full", p0_ready, 0);
    chk("t4_p1_ready", p1_ready, 1);
    cyc(); p1_wen = 0;
    chk("t4_no_read_full", mem_ren, 0);
    chk("t4_no_wen_yet", mem_wen, 0);
    cyc();
    chk("t4_wen_full", mem_wen, 1);
    chk("t4_wen_addr", mem_addr, 32'h90);
    chk("t4_wen_wdata", mem_wdata, 32'h55);
    chk("t4_wen_no_ren", mem_ren, 0);
    mem_valid = 1; mem_rdata = 32'h11; #1;
    chk("t4_pop_p0_valid", p0_valid, 1);
    cyc(); mem_valid = 0;
    chk("t4_not_same_edge", mem_ren, 0);
    cyc();
    chk("t4_resume_ren", mem_ren, 1);
    chk("t4_resume_addr", mem_addr, 32'h20);

    // 5: p1 write, no tag push
    do_reset();
    p1_addr = 32'h80; p1_wdata = 32'h12345678; p1_wen = 1;
    cyc(); p1_wen = 0;
    cyc();
    chk("t5_wen", mem_wen, 1);
    chk("t5_ren", mem_ren, 0);
    chk("t5_addr", mem_addr, 32'h80);
    chk("t5_wdata", mem_wdata, 32'h12345678);
    cyc();
    chk("t5_wen_end", mem_wen, 0);
    chk("t5_addr_hold", mem_addr, 32'h80);
    // 6: response with nothing outstanding
    mem_valid = 1; mem_rdata = 32'h77; #1;
    chk("t6_spur_p0_valid", p0_valid, 0);
    chk("t6_spur_p1_valid", p1_valid, 0);
    cyc(); mem_valid = 0;
    chk("t6_err_set", err, 1);
    cyc();
    chk("t6_err_sticky", err, 1);
    p0_addr = 32'h500; p0_ren = 1;
    cyc(); p0_addr = 32'h504;
    cyc(); p0_ren = 0;
    chk("t6_burst_ren", mem_ren, 1);
    chk("t6_burst_addr", mem_addr, 32'h500);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_ren", mem_ren, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_p0_ready", p0_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    cyc();
    mem_valid = 1;
    cyc(); mem_valid = 0;
    chk("t6_stale_rsp_err", err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
